// File: rtl/dpa_pkg.sv
// dpa_pkg: shared types and defaults for the sequential slice subtractor.
// Holds the controller state encoding, default widths and the slice-index width helper.
package dpa_pkg;

    localparam int unsigned DefaultN = 64;
    localparam int unsigned DefaultW = 16;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } dpa_state_e;

    // Slice index width: $clog2(N/W), but never narrower than one bit.
    function automatic int unsigned dpa_kw(input int unsigned n, input int unsigned w);
        int unsigned lg;
        lg = $clog2(n / w);
        return (lg < 1) ? 1 : lg;
    endfunction

endpackage

// File: rtl/dpa_sub_seq_if.sv
// dpa_sub_seq_if: operand/result handshake bundle for dpa_sub_seq.
// master = operand producer / result consumer, slave = the subtractor.
interface dpa_sub_seq_if #(
    parameter int unsigned N = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         signed_en;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         bout;
    logic         negative_flag;
    logic         overflow_flag;
    logic         zero_flag;

    modport master (
        output in_valid, a, b, bin, signed_en, out_ready,
        input  in_ready, out_valid, diff, bout, negative_flag, overflow_flag, zero_flag
    );

    modport slave (
        input  in_valid, a, b, bin, signed_en, out_ready,
        output in_ready, out_valid, diff, bout, negative_flag, overflow_flag, zero_flag
    );

endinterface

// File: rtl/dpa_slice.sv
// dpa_slice: combinational W-bit precompute / carry-select adder.
// Both candidate sums (carry-in 0 and 1) are formed up front; cin only picks one.
module dpa_slice #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);
    logic [W:0] sum0;
    logic [W:0] sum1;

    // Precompute both outcomes, then select by the incoming carry.
    always_comb begin
        sum0 = {1'b0, x} + {1'b0, y};
        sum1 = {1'b0, x} + {1'b0, y} + (W+1)'(1);
        s    = cin ? sum1[W-1:0] : sum0[W-1:0];
        cout = cin ? sum1[W] : sum0[W];
    end

endmodule

// File: rtl/dpa_sub_seq.sv
// dpa_sub_seq: sequential a - b - bin, one W-bit slice per cycle behind valid/ready.
// Optional feature macro MAG_OUT_EN: adds a FIX cycle that turns a negative signed
// result into its magnitude (flags still describe the raw two's-complement result).
module dpa_sub_seq
    import dpa_pkg::*;
#(
    parameter int unsigned N = DefaultN,
    parameter int unsigned W = DefaultW
) (
    input  logic          clk,
    input  logic          rst,
    dpa_sub_seq_if.slave  bus
);
    localparam int unsigned NS = N / W;
    localparam int unsigned KW = dpa_kw(N, W);

    if (N % W != 0) begin : g_bad_width
        $error("dpa_sub_seq: N must be a multiple of W");
    end

    dpa_state_e    state_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic          signed_q;
    logic [KW-1:0] k_q;
    logic          carry_q;
    logic [N-1:0]  diff_q;
    logic          bout_q;
    logic          neg_q;
    logic          ovf_q;
    logic          in_ready_q;
    logic          out_valid_q;

    logic [W-1:0]  slice_x;
    logic [W-1:0]  slice_y;
    logic [W-1:0]  slice_s;
    logic          slice_cout;
    logic [N-1:0]  r_full;
    logic          last_slice;

    // Select the current slice; subtraction is a + ~b + carry, carry seeded with ~bin.
    always_comb begin
        slice_x            = a_q[k_q*W +: W];
        slice_y            = ~b_q[k_q*W +: W];
        r_full             = diff_q;
        r_full[k_q*W +: W] = slice_s;
        last_slice         = (k_q == KW'(NS - 1));
    end

    dpa_slice #(
        .W (W)
    ) u_slice (
        .x    (slice_x),
        .y    (slice_y),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // Controller and datapath registers; all outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            signed_q    <= 1'b0;
            k_q         <= '0;
            carry_q     <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        signed_q   <= bus.signed_en;
                        carry_q    <= ~bus.bin;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StCalc;
                    end
                end
                StCalc: begin
                    diff_q[k_q*W +: W] <= slice_s;
                    carry_q            <= slice_cout;
                    k_q                <= last_slice ? '0 : k_q + KW'(1);
                    if (last_slice) begin
                        // Flags come from the raw result; the final carry never propagates further.
                        bout_q <= ~slice_cout;
                        neg_q  <= signed_q & r_full[N-1];
                        ovf_q  <= signed_q ? ((a_q[N-1] ^ b_q[N-1]) & (r_full[N-1] ^ a_q[N-1]))
                                           : ~slice_cout;
`ifdef MAG_OUT_EN
                        state_q <= StFix;
`else
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
`endif
                    end
                end
`ifdef MAG_OUT_EN
                StFix: begin
                    if (signed_q && diff_q[N-1]) begin
                        diff_q <= ~diff_q + N'(1);
                    end
                    state_q     <= StDone;
                    out_valid_q <= 1'b1;
                end
`endif
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.diff          = diff_q;
    assign bus.bout          = bout_q;
    assign bus.negative_flag = neg_q;
    assign bus.overflow_flag = ovf_q;
    assign bus.zero_flag     = (diff_q == '0);

endmodule
